// File: rtl/rgb_ycbcr_pipe_pkg.sv
// Shared definitions for the RGB-to-YCbCr pipeline.
// Contents:
//   mode_e      output mode selector (YCbCr, grey, passthrough, threshold)
//   sideband_t  video qualifier and sync bits that travel with each pixel
//   Coef*       8-bit unsigned coefficient magnitudes; the signs live in the lanes
//   RoundConst  half-LSB added to every sum ahead of the fractional shift
//   ofs()       mid-scale chroma offset for a given component width
package ycbcr_pkg;

  typedef enum logic [1:0] {
    MODE_YCBCR  = 2'd0,
    MODE_GREY   = 2'd1,
    MODE_PASS   = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;

  typedef struct packed {
    logic valid;
    logic de;
    logic hs;
    logic vs;
  } sideband_t;

  // Luma
  localparam int unsigned CoefYR  = 77;
  localparam int unsigned CoefYG  = 150;
  localparam int unsigned CoefYB  = 29;
  // Blue-difference chroma (R and G terms are subtracted)
  localparam int unsigned CoefCbR = 43;
  localparam int unsigned CoefCbG = 85;
  localparam int unsigned CoefCbB = 128;
  // Red-difference chroma (G and B terms are subtracted)
  localparam int unsigned CoefCrR = 128;
  localparam int unsigned CoefCrG = 107;
  localparam int unsigned CoefCrB = 21;

  localparam int unsigned RoundConst = 128;

  // Mid-scale offset in the pre-shift domain: 2^(comp_w-1) scaled by 2^8.
  function automatic int unsigned ofs(input int unsigned comp_w);
    return 32'd1 << (comp_w + 7);
  endfunction

endpackage

// File: rtl/rgb_ycbcr_pipe_if.sv
// Pixel bus between the frame source and the converter.
// Signals:
//   in_valid/in_de/in_hs/in_vs  pixel qualifier and video sync sideband into the pipe
//   in_rgb                      {R,G,B}, R in the MSBs
//   mode_sel/thresh             requested output mode and luma threshold
//   out_valid/out_de/out_hs/out_vs  sideband, three cycles later
//   out_data                    converted pixel, first component in the MSBs
//   mode_active                 mode currently in force
// master: the frame source side; slave: the converter.
interface rgb_ycbcr_pipe_if #(
  parameter int unsigned COMP_W = 8
);

  logic                  in_valid;
  logic                  in_de;
  logic                  in_hs;
  logic                  in_vs;
  logic [3*COMP_W-1:0]   in_rgb;
  logic [1:0]            mode_sel;
  logic [COMP_W-1:0]     thresh;

  logic                  out_valid;
  logic                  out_de;
  logic                  out_hs;
  logic                  out_vs;
  logic [3*COMP_W-1:0]   out_data;
  logic [1:0]            mode_active;

  modport master (
    output in_valid, in_de, in_hs, in_vs, in_rgb, mode_sel, thresh,
    input  out_valid, out_de, out_hs, out_vs, out_data, mode_active
  );

  modport slave (
    input  in_valid, in_de, in_hs, in_vs, in_rgb, mode_sel, thresh,
    output out_valid, out_de, out_hs, out_vs, out_data, mode_active
  );

endinterface

// File: rtl/rgb_ycbcr_pipe_lane.sv
// One colour-space output channel: three weighted products, a signed sum with
// rounding and offset, then a fractional shift and clamp to the component range.
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   r_i/g_i/b_i   input components (stage 0)
//   result_o      clamped component, combinational from the stage-2 sum register,
//                 so it is valid in the same cycle as the top-level stage-2 sideband
module ycbcr_lane
  import ycbcr_pkg::*;
#(
  parameter int unsigned CompW  = 8,
  parameter int unsigned FracW  = 8,
  parameter int unsigned CoefR  = 0,
  parameter int unsigned CoefG  = 0,
  parameter int unsigned CoefB  = 0,
  parameter bit          NegR   = 1'b0,
  parameter bit          NegG   = 1'b0,
  parameter bit          NegB   = 1'b0,
  parameter int unsigned Offset = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CompW-1:0] r_i,
  input  logic [CompW-1:0] g_i,
  input  logic [CompW-1:0] b_i,
  output logic [CompW-1:0] result_o
);

  localparam int unsigned ProdW = CompW + 8;
  localparam int unsigned SumW  = CompW + 10;

  localparam logic signed [SumW-1:0] Bias = SumW'(RoundConst + Offset);

  logic        [ProdW-1:0] prod_r_d, prod_g_d, prod_b_d;
  logic        [ProdW-1:0] prod_r_q, prod_g_q, prod_b_q;
  logic signed [SumW-1:0]  sum_d, sum_q;
  logic signed [SumW-1:0]  shifted;

  // Zero-extend an unsigned product into the signed sum domain, negating on request.
  function automatic logic signed [SumW-1:0] term(input logic [ProdW-1:0] p, input bit neg);
    logic signed [SumW-1:0] ext;
    ext = $signed({2'b00, p});
    return neg ? -ext : ext;
  endfunction

  // Coefficients are below 256, so every product fits in CompW+8 bits; the x128
  // weights reduce to shifts in synthesis.
  always_comb begin
    prod_r_d = ProdW'(r_i) * ProdW'(CoefR);
    prod_g_d = ProdW'(g_i) * ProdW'(CoefG);
    prod_b_d = ProdW'(b_i) * ProdW'(CoefB);
  end

  always_comb begin
    sum_d = term(prod_r_q, NegR) + term(prod_g_q, NegG) + term(prod_b_q, NegB) + Bias;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      sum_q    <= '0;
    end else begin
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      sum_q    <= sum_d;
    end
  end

  // Arithmetic shift keeps the sign so negative sums clamp to zero; any set bit
  // above the component width means overflow and clamps to all-ones.
  always_comb begin
    shifted  = sum_q >>> FracW;
    result_o = shifted[CompW-1:0];
    if (shifted[SumW-1]) begin
      result_o = '0;
    end else if (|shifted[SumW-2:CompW]) begin
      result_o = '1;
    end
  end

endmodule

// File: rtl/rgb_ycbcr_pipe.sv
// Fully pipelined RGB-to-YCbCr converter with YCbCr 4:4:4, grey, passthrough and
// binary-threshold output modes. Three cycles from input to output for data and
// every sideband bit. Mode and threshold are latched only on a vsync rising edge
// and ride along with each pixel, so a frame never mixes two modes.
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset; clears the pipeline, outputs and mode
//   bus    pixel bus (slave side): input pixel/sideband/mode request, output
//          pixel/sideband and mode_active
module rgb_ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int unsigned COMP_W    = 8,
  parameter int unsigned COEF_FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rgb_ycbcr_pipe_if.slave bus
);

  localparam int unsigned DataW = 3 * COMP_W;

  logic [COMP_W-1:0] in_r, in_g, in_b;
  logic [COMP_W-1:0] lane_y, lane_cb, lane_cr;

  // Vsync edge detect and latched mode
  logic              vs_q;
  logic              vs_rise;
  mode_e             mode_d, mode_q;
  logic [COMP_W-1:0] thresh_d, thresh_q;

  // Delay lines matched to the lane pipeline
  sideband_t         in_sb;
  sideband_t         s1_sb_q, s2_sb_q, out_sb_q;
  mode_e             s1_mode_q, s2_mode_q;
  logic [COMP_W-1:0] s1_thresh_q, s2_thresh_q;
  logic [DataW-1:0]  s1_rgb_q, s2_rgb_q;

  logic [DataW-1:0]  mux_data;
  logic [DataW-1:0]  out_data_d, out_data_q;

  assign in_r = bus.in_rgb[3*COMP_W-1:2*COMP_W];
  assign in_g = bus.in_rgb[2*COMP_W-1:COMP_W];
  assign in_b = bus.in_rgb[COMP_W-1:0];

  assign in_sb = '{valid: bus.in_valid, de: bus.in_de, hs: bus.in_hs, vs: bus.in_vs};

  // The pixel entering on the rising-edge cycle already takes the new mode, so the
  // stage-1 mode comes from mode_d rather than mode_q.
  always_comb begin
    vs_rise  = bus.in_vs & ~vs_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    if (vs_rise) begin
      mode_d   = mode_e'(bus.mode_sel);
      thresh_d = bus.thresh;
    end
  end

  ycbcr_lane #(
    .CompW  (COMP_W),
    .FracW  (COEF_FRAC),
    .CoefR  (CoefYR),
    .CoefG  (CoefYG),
    .CoefB  (CoefYB),
    .NegR   (1'b0),
    .NegG   (1'b0),
    .NegB   (1'b0),
    .Offset (0)
  ) u_lane_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_i      (in_r),
    .g_i      (in_g),
    .b_i      (in_b),
    .result_o (lane_y)
  );

  ycbcr_lane #(
    .CompW  (COMP_W),
    .FracW  (COEF_FRAC),
    .CoefR  (CoefCbR),
    .CoefG  (CoefCbG),
    .CoefB  (CoefCbB),
    .NegR   (1'b1),
    .NegG   (1'b1),
    .NegB   (1'b0),
    .Offset (ofs(COMP_W))
  ) u_lane_cb (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_i      (in_r),
    .g_i      (in_g),
    .b_i      (in_b),
    .result_o (lane_cb)
  );

  ycbcr_lane #(
    .CompW  (COMP_W),
    .FracW  (COEF_FRAC),
    .CoefR  (CoefCrR),
    .CoefG  (CoefCrG),
    .CoefB  (CoefCrB),
    .NegR   (1'b0),
    .NegG   (1'b1),
    .NegB   (1'b1),
    .Offset (ofs(COMP_W))
  ) u_lane_cr (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_i      (in_r),
    .g_i      (in_g),
    .b_i      (in_b),
    .result_o (lane_cr)
  );

  // Stage-3 select uses the mode captured alongside the pixel, not mode_q.
  always_comb begin
    mux_data = '0;
    unique case (s2_mode_q)
      MODE_YCBCR:  mux_data = {lane_y, lane_cb, lane_cr};
      MODE_GREY:   mux_data = {lane_y, lane_y, lane_y};
      MODE_PASS:   mux_data = s2_rgb_q;
      MODE_THRESH: mux_data = {DataW{lane_y >= s2_thresh_q}};
      default:     mux_data = '0;
    endcase
    out_data_d = s2_sb_q.valid ? mux_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      mode_q      <= MODE_YCBCR;
      thresh_q    <= '0;
      s1_sb_q     <= '0;
      s2_sb_q     <= '0;
      out_sb_q    <= '0;
      s1_mode_q   <= MODE_YCBCR;
      s2_mode_q   <= MODE_YCBCR;
      s1_thresh_q <= '0;
      s2_thresh_q <= '0;
      s1_rgb_q    <= '0;
      s2_rgb_q    <= '0;
      out_data_q  <= '0;
    end else begin
      vs_q        <= bus.in_vs;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      s1_sb_q     <= in_sb;
      s2_sb_q     <= s1_sb_q;
      out_sb_q    <= s2_sb_q;
      s1_mode_q   <= mode_d;
      s2_mode_q   <= s1_mode_q;
      s1_thresh_q <= thresh_d;
      s2_thresh_q <= s1_thresh_q;
      s1_rgb_q    <= bus.in_rgb;
      s2_rgb_q    <= s1_rgb_q;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid   = out_sb_q.valid;
  assign bus.out_de      = out_sb_q.de;
  assign bus.out_hs      = out_sb_q.hs;
  assign bus.out_vs      = out_sb_q.vs;
  assign bus.out_data    = out_data_q;
  assign bus.mode_active = mode_q;

endmodule

// File: tb/tb_rgb_ycbcr_pipe.sv
// Scoreboard bench for rgb_ycbcr_pipe at COMP_W=8 and COMP_W=10. Stimulus pushes
// the expected pixel (value, sideband and arrival cycle) into a per-DUT queue; a
// monitor per DUT pops and compares whenever out_valid is high, and checks that
// out_data is zero on every idle cycle.
module tb_rgb_ycbcr_pipe;

  typedef struct {
    int          cyc;
    logic [35:0] data;
    logic [2:0]  sb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q8[$];
  exp_t q10[$];
  exp_t e8, e10;

  rgb_ycbcr_pipe_if #(.COMP_W(8))  if8 ();
  rgb_ycbcr_pipe_if #(.COMP_W(10)) if10 ();

  rgb_ycbcr_pipe #(.COMP_W(8), .COEF_FRAC(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  rgb_ycbcr_pipe #(.COMP_W(10), .COEF_FRAC(8)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Integer reference for the converter output.
  function automatic logic [35:0] model(input int w, input logic [35:0] rgb, input int mode,
                                        input int th);
    int     mx, r, g, b, ofs, y, cb, cr;
    longint res;
    mx  = (1 << w) - 1;
    r   = int'(rgb >> (2 * w)) & mx;
    g   = int'(rgb >> w) & mx;
    b   = int'(rgb) & mx;
    ofs = 1 << (w + 7);
    y   = clampv((77 * r + 150 * g + 29 * b + 128) >>> 8, mx);
    cb  = clampv((128 * b - 43 * r - 85 * g + ofs + 128) >>> 8, mx);
    cr  = clampv((128 * r - 107 * g - 21 * b + ofs + 128) >>> 8, mx);
    case (mode)
      0:       res = (longint'(y) << (2 * w)) | (longint'(cb) << w) | longint'(cr);
      1:       res = (longint'(y) << (2 * w)) | (longint'(y) << w) | longint'(y);
      2:       res = longint'(rgb);
      default: res = (y >= th) ? ((longint'(1) << (3 * w)) - 1) : 0;
    endcase
    return 36'(res);
  endfunction

  task automatic drive8(input logic v, input logic de, input logic hs, input logic vs,
                        input logic [23:0] rgb, input logic [1:0] m, input logic [7:0] th,
                        input logic [35:0] exp);
    @(negedge clk);
    if8.in_valid = v;
    if8.in_de    = de;
    if8.in_hs    = hs;
    if8.in_vs    = vs;
    if8.in_rgb   = rgb;
    if8.mode_sel = m;
    if8.thresh   = th;
    if (v) q8.push_back('{cyc: cyc + 3, data: exp, sb: {de, hs, vs}});
  endtask

  task automatic drive10(input logic v, input logic de, input logic hs, input logic vs,
                         input logic [29:0] rgb, input logic [1:0] m, input logic [9:0] th,
                         input logic [35:0] exp);
    @(negedge clk);
    if10.in_valid = v;
    if10.in_de    = de;
    if10.in_hs    = hs;
    if10.in_vs    = vs;
    if10.in_rgb   = rgb;
    if10.mode_sel = m;
    if10.thresh   = th;
    if (v) q10.push_back('{cyc: cyc + 3, data: exp, sb: {de, hs, vs}});
  endtask

  task automatic set_mode8(input logic [1:0] m, input logic [7:0] th);
    drive8(0, 0, 0, 0, 24'h0, m, th, 36'h0);
    drive8(0, 0, 0, 1, 24'h0, m, th, 36'h0);
    drive8(0, 0, 0, 0, 24'h0, m, th, 36'h0);
    check("mode_active8 after vs rise", 36'(if8.mode_active), 36'(m));
  endtask

  task automatic set_mode10(input logic [1:0] m, input logic [9:0] th);
    drive10(0, 0, 0, 0, 30'h0, m, th, 36'h0);
    drive10(0, 0, 0, 1, 30'h0, m, th, 36'h0);
    drive10(0, 0, 0, 0, 30'h0, m, th, 36'h0);
    check("mode_active10 after vs rise", 36'(if10.mode_active), 36'(m));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut8 outputs"}, 36'({if8.out_valid, if8.out_de, if8.out_hs, if8.out_vs,
                                       if8.out_data, if8.mode_active}), 36'h0);
    check({tag, " dut10 outputs"}, {if10.out_valid, if10.out_de, if10.out_hs, if10.out_vs,
                                    if10.out_data, if10.mode_active}, 36'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (if8.out_valid) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut8 unexpected pixel: got %h, expected none (cycle %0d)",
                   if8.out_data, cyc);
        end else begin
          e8 = q8.pop_front();
          check("dut8 latency", 36'(cyc), 36'(e8.cyc));
          check("dut8 data", 36'(if8.out_data), e8.data);
          check("dut8 sideband", 36'({if8.out_de, if8.out_hs, if8.out_vs}), 36'(e8.sb));
        end
      end else begin
        check("dut8 idle data", 36'(if8.out_data), 36'h0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (if10.out_valid) begin
        if (q10.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut10 unexpected pixel: got %h, expected none (cycle %0d)",
                   if10.out_data, cyc);
        end else begin
          e10 = q10.pop_front();
          check("dut10 latency", 36'(cyc), 36'(e10.cyc));
          check("dut10 data", 36'(if10.out_data), e10.data);
          check("dut10 sideband", 36'({if10.out_de, if10.out_hs, if10.out_vs}), 36'(e10.sb));
        end
      end else begin
        check("dut10 idle data", 36'(if10.out_data), 36'h0);
      end
    end
  end

  initial begin
    logic [23:0] rgb8;
    logic [29:0] rgb10;
    logic        v, de, hs, vs;

    rst_n = 1'b0;
    {if8.in_valid, if8.in_de, if8.in_hs, if8.in_vs} = 4'b0;
    if8.in_rgb = '0;
    if8.mode_sel = '0;
    if8.thresh = '0;
    {if10.in_valid, if10.in_de, if10.in_hs, if10.in_vs} = 4'b0;
    if10.in_rgb = '0;
    if10.mode_sel = '0;
    if10.thresh = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("power-on reset");
    rst_n = 1'b1;

    // Colour points, YCbCr mode out of reset
    drive8(1, 1, 0, 0, 24'hFFFFFF, 0, 0, 36'hFF8080);
    drive8(1, 1, 0, 0, 24'h000000, 0, 0, 36'h008080);
    drive8(1, 1, 1, 0, 24'hFF0000, 0, 0, 36'h4D55FF);
    drive8(1, 1, 0, 0, 24'h0000FF, 0, 0, 36'h1DFF6B);
    drive8(0, 0, 0, 0, 24'h0, 0, 0, 36'h0);

    // Grey
    set_mode8(1, 8'h00);
    drive8(1, 1, 0, 0, 24'hFF0000, 1, 0, 36'h4D4D4D);
    drive8(1, 1, 0, 0, 24'h0000FF, 1, 0, 36'h1D1D1D);

    // Threshold, including the equal/one-below boundary on a neutral grey
    set_mode8(3, 8'h4D);
    drive8(1, 1, 0, 0, 24'hFF0000, 3, 8'h4D, 36'hFFFFFF);
    drive8(1, 1, 0, 0, 24'h0000FF, 3, 8'h4D, 36'h000000);
    drive8(1, 1, 0, 0, 24'h4D4D4D, 3, 8'h4D, 36'hFFFFFF);
    drive8(1, 1, 0, 0, 24'h4C4C4C, 3, 8'h4D, 36'h000000);

    // Mid-frame requests are ignored; the rising-edge pixel takes the new mode
    drive8(1, 1, 0, 0, 24'hFF0000, 0, 8'h00, 36'hFFFFFF);
    drive8(1, 1, 0, 0, 24'h4C4C4C, 0, 8'h00, 36'h000000);
    check("mode_active8 ignores mid-frame", 36'(if8.mode_active), 36'd3);
    drive8(1, 1, 0, 1, 24'hFF0000, 0, 8'h00, 36'h4D55FF);
    drive8(1, 1, 0, 1, 24'h0000FF, 1, 8'h00, 36'h1DFF6B);
    check("mode_active8 switched", 36'(if8.mode_active), 36'd0);
    drive8(1, 1, 0, 0, 24'h0000FF, 1, 8'h00, 36'h1DFF6B);
    check("mode_active8 held", 36'(if8.mode_active), 36'd0);

    // Random YCbCr sweep with gaps in valid
    for (int i = 0; i < 24; i++) begin
      rgb8 = 24'($urandom);
      v    = 1'($urandom_range(0, 1));
      drive8(v, v, 0, 0, rgb8, 0, 0, model(8, 36'(rgb8), 0, 0));
    end

    // Passthrough with random sideband; vs rises keep re-latching passthrough
    set_mode8(2, 8'h00);
    for (int i = 0; i < 60; i++) begin
      rgb8 = 24'($urandom);
      {v, de, hs, vs} = 4'($urandom);
      drive8(v, de, hs, vs, rgb8, 2, 0, 36'(rgb8));
    end

    // Reset mid-stream drops in-flight pixels and the latched mode
    set_mode8(1, 8'h00);
    drive8(1, 1, 0, 0, 24'h123456, 1, 0, 36'h0);
    drive8(1, 1, 0, 0, 24'h654321, 1, 0, 36'h0);
    @(negedge clk);
    rst_n = 1'b0;
    {if8.in_valid, if8.in_de, if8.in_hs, if8.in_vs} = 4'b0;
    if8.mode_sel = '0;
    q8.delete();
    #1;
    check_reset_outputs("mid-stream reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset held");
    rst_n = 1'b1;
    drive8(1, 1, 0, 0, 24'hFFFFFF, 0, 0, 36'hFF8080);
    drive8(0, 0, 0, 0, 24'h0, 0, 0, 36'h0);

    // Ten-bit components
    drive10(1, 1, 0, 0, 30'h3FFFFFFF, 0, 0, 36'h3FF80200);
    drive10(1, 1, 0, 0, 30'h00000000, 0, 0, 36'h00080200);
    for (int i = 0; i < 30; i++) begin
      rgb10 = 30'($urandom);
      v     = 1'($urandom_range(0, 1));
      drive10(v, 1, v, 0, rgb10, 0, 0, model(10, 36'(rgb10), 0, 0));
    end
    set_mode10(3, 10'h200);
    for (int i = 0; i < 12; i++) begin
      rgb10 = 30'($urandom);
      drive10(1, 1, 0, 0, rgb10, 3, 10'h200, model(10, 36'(rgb10), 3, 'h200));
    end
    drive10(0, 0, 0, 0, 30'h0, 3, 10'h200, 36'h0);

    for (int i = 0; i < 20 && (q8.size() != 0 || q10.size() != 0); i++) @(negedge clk);
    if (q8.size() != 0 || q10.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d pixels outstanding, expected 0", q8.size(), q10.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
